pix_delay_align: RTL
====================

Name: pix_delay_align

Overview:
- Parametrised delay line for one pixel stream: data plus vsync/href/clken, all delayed by the same number of clocks.
- Realigns a pass-through stream with the output of a windowed filter stage (median, Sobel, etc.) of known latency.
- Delay is selectable at run time, up to MAX_DLY.
- A new delay value takes effect only at a frame boundary, so a frame never tears.

Parameters:
- DATA_W, 24, pixel data width in bits.
- MAX_DLY, 16, maximum delay in clocks; range 2..64.
- DLY_W, 7, width of delay-select and status ports; must satisfy 2^DLY_W > MAX_DLY.
- DEFAULT_DLY, 7, active delay after reset; range 1..MAX_DLY.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- dly_sel  in  DLY_W  requested delay in clocks, sampled at frame start
- in_vsync  in  1  input frame sync
- in_href  in  1  input line valid
- in_clken  in  1  input pixel valid
- in_data  in  DATA_W  input pixel
- out_vsync  out  1  delayed vsync
- out_href  out  1  delayed href
- out_clken  out  1  delayed clken
- out_data  out  DATA_W  delayed pixel
- dly_cur  out  DLY_W  active delay value
- cfg_err  out  1  sticky: an out-of-range dly_sel was sampled

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is asynchronous and active-low on reset_n; all flops clear when reset_n is low.
- Reset values:
  - All stage registers, out_vsync, out_href, out_clken, out_data, cfg_err = 0.
  - dly_cur = DEFAULT_DLY.
  - Internal vs_d (previous in_vsync) = 0.
- Stage chain:
  - MAX_DLY stages, each holding {vsync, href, clken, data}.
  - The chain shifts every clock, unconditionally; stage[0] <= inputs.
- Output tap:
  - Outputs are the stage[dly_cur-1] tap, selected by a mux driven only by registers.
  - Hence an input presented before edge N appears at the outputs after edge N+dly_cur-1. Latency = dly_cur clocks, measured as the number of edges from input sample to output change.
  - All four signals are delayed identically, so sync alignment is preserved.
- Frame-boundary reload:
  - Rising edge of in_vsync (in_vsync=1, vs_d=0) marks a frame boundary.
  - At that edge, dly_cur <= clamp(dly_sel). The new tap is used from the next cycle on.
  - dly_sel changes at any other time are ignored.
  - If dly_sel changes on the same edge as the rising vsync, the value present at that edge is used.
- Clamping:
  - dly_sel = 0 loads 1.
  - dly_sel > MAX_DLY loads MAX_DLY.
  - Either case sets cfg_err = 1. cfg_err clears only on reset.
- Switch-over:
  - On the cycles after a delay change, outputs show the contents of the new tap stage.
  - Shrinking the delay skips samples; growing it repeats them.
  - This is acceptable because the switch happens in vertical blanking. No other masking is applied.
- vsync held high:
  - Only the rising edge reloads; a constant-high vsync causes no further reloads.
- Reset mid-frame:
  - Chain is flushed to 0 and delay returns to DEFAULT_DLY.
  - Outputs are 0 until new input propagates through the chain.

Optional Feature:
- Macro: PIX_DLY_ZERO_GATE_EN.
- Defined: out_data is forced to 0 whenever out_clken = 0. Blanking data is therefore clean for downstream adders and histograms.
- Undefined: out_data is the raw tap data regardless of out_clken. This saves the gating logic.
- Sync outputs and dly_cur are unaffected in both builds.

Test Plan:
- Reset latency: release reset with DEFAULT_DLY=7; drive in_clken=1, in_data=0x000001 for one cycle at edge 0 -> out_clken=1, out_data=0x000001 exactly after edge 6; all outputs 0 before that.
- Delay change at frame start: dly_sel=3, pulse in_vsync high for one line -> dly_cur=3 from the cycle after the rising edge; the next pixel ramp 0x10, 0x11, ... appears 3 clocks after input; out_vsync aligned to in_vsync +3.
- Mid-frame ignore: with dly_cur=3, change dly_sel to 12 during active href -> dly_cur stays 3 and outputs stay 3-clock aligned until the next vsync rise, then dly_cur=12.
- Clamp: sample dly_sel=0 at a vsync rise -> dly_cur=1, cfg_err=1. Next frame dly_sel=40 (MAX_DLY=16) -> dly_cur=16, cfg_err stays 1 until reset.
- Gating: in_href=1, in_clken alternating 1/0, in_data=0xABCDEF constant -> with PIX_DLY_ZERO_GATE_EN, out_data alternates 0xABCDEF/0x000000; without it, out_data is constant 0xABCDEF.
- Async reset mid-stream: assert reset_n low between edges during active data -> outputs go to 0 immediately without waiting for a clock, dly_cur=DEFAULT_DLY, and recovery latency matches the first test.

Source files
------------

// File: rtl/pix_delay_align_if.sv
// Pixel stream bundle for pix_delay_align: input stream, delay select, delayed stream and status.
// master drives the input stream and dly_sel; slave is the delay line itself.
interface pix_delay_align_if #(
  parameter int DATA_W = 24,
  parameter int DLY_W  = 7
);
  logic [DLY_W-1:0]  dly_sel;
  logic              in_vsync;
  logic              in_href;
  logic              in_clken;
  logic [DATA_W-1:0] in_data;
  logic              out_vsync;
  logic              out_href;
  logic              out_clken;
  logic [DATA_W-1:0] out_data;
  logic [DLY_W-1:0]  dly_cur;
  logic              cfg_err;

  modport master (
    output dly_sel, in_vsync, in_href, in_clken, in_data,
    input  out_vsync, out_href, out_clken, out_data, dly_cur, cfg_err
  );

  modport slave (
    input  dly_sel, in_vsync, in_href, in_clken, in_data,
    output out_vsync, out_href, out_clken, out_data, dly_cur, cfg_err
  );
endinterface

// File: rtl/pix_delay_align.sv
// Pixel delay line (vsync/href/clken/data), delay dly_cur clocks, reloaded only at in_vsync rise; no backpressure.
// `PIX_DLY_ZERO_GATE_EN forces out_data to 0 while out_clken is low.
module pix_delay_align #(
  parameter int DATA_W      = 24,
  parameter int MAX_DLY     = 16,
  parameter int DLY_W       = 7,
  parameter int DEFAULT_DLY = 7
) (
  input  logic                clk,
  input  logic                reset_n,
  pix_delay_align_if.slave    bus
);

  typedef struct packed {
    logic              vsync;
    logic              href;
    logic              clken;
    logic [DATA_W-1:0] data;
  } pix_t;

  localparam logic [DLY_W-1:0] MAX_V = DLY_W'(MAX_DLY);
  localparam logic [DLY_W-1:0] DEF_V = DLY_W'(DEFAULT_DLY);

  pix_t             stage_q [MAX_DLY];
  pix_t             in_pix;
  pix_t             tap;
  logic             vs_q;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic             err_q, err_d;
  logic [DLY_W-1:0] sel_clamped;
  logic             sel_bad;
  logic             frame_rise;

  assign in_pix = '{vsync: bus.in_vsync, href: bus.in_href,
                    clken: bus.in_clken, data: bus.in_data};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_DLY; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= in_pix;
      for (int i = 1; i < MAX_DLY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  always_comb begin
    sel_clamped = bus.dly_sel;
    sel_bad     = 1'b0;
    if (bus.dly_sel == '0) begin
      sel_clamped = DLY_W'(1);
      sel_bad     = 1'b1;
    end else if (bus.dly_sel > MAX_V) begin
      sel_clamped = MAX_V;
      sel_bad     = 1'b1;
    end
  end

  // Reload only on the vsync rising edge so a frame never sees two tap positions.
  assign frame_rise = bus.in_vsync & ~vs_q;

  always_comb begin
    dly_d = dly_q;
    err_d = err_q;
    if (frame_rise) begin
      dly_d = sel_clamped;
      err_d = err_q | sel_bad;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_q  <= 1'b0;
      dly_q <= DEF_V;
      err_q <= 1'b0;
    end else begin
      vs_q  <= bus.in_vsync;
      dly_q <= dly_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    tap = stage_q[0];
    for (int i = 0; i < MAX_DLY; i++) begin
      if (dly_q == DLY_W'(i + 1)) tap = stage_q[i];
    end
  end

  assign bus.out_vsync = tap.vsync;
  assign bus.out_href  = tap.href;
  assign bus.out_clken = tap.clken;
  assign bus.dly_cur   = dly_q;
  assign bus.cfg_err   = err_q;

`ifdef PIX_DLY_ZERO_GATE_EN
  assign bus.out_data = tap.clken ? tap.data : '0;
`else
  assign bus.out_data = tap.data;
`endif

endmodule
